// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the HI/LO multiply/divide sequencer.
package cpu_pkg;

  localparam int HILO_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } hilo_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_DIV   = 2'd2,
    S_FIXUP = 2'd3
  } hilo_state_t;

endpackage

// File: rtl/hilo_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO pair.
// Operands are reduced to magnitudes at acceptance, iterated one bit per cycle
// through a single shared add/subtract on a (2*WIDTH+1)-bit accumulator, and
// the signs are applied in a final FIXUP cycle that also writes HI/LO.
module hilo_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_EX,
  input  logic [1:0]       op_EX,
  input  logic [WIDTH-1:0] a_EX,
  input  logic [WIDTH-1:0] b_EX,
  input  logic             rd_req_EX,
  input  logic             mt_we_EX,
  input  logic             sel_hi_EX,
  input  logic [WIDTH-1:0] mt_data_EX,
  output logic [WIDTH-1:0] rd_data_EX,
  output logic             stall_FETCH,
  output logic             busy,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = 2 * WIDTH + 1;

  // Conditional two's-complement negate, operand width.
  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Conditional two's-complement negate, double width.
  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  hilo_state_t      state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             dbz_q;

  hilo_op_t         op_q;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] m_q, a_raw_q;
  logic             neg_q, rneg_q, dvz_q;

  logic             accept, signed_op, new_is_div, op_is_div, step_is_div;
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   x_s, rem_s;
  logic [WIDTH+1:0] y_s, sum_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] hi_fix, lo_fix;

  assign accept      = (state_q == S_IDLE) && start_EX;
  assign signed_op   = (op_EX == OP_MULT) || (op_EX == OP_DIV);
  assign new_is_div  = (op_EX == OP_DIV) || (op_EX == OP_DIVU);
  assign op_is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign step_is_div = (state_q == S_DIV);
  assign sa          = signed_op & a_EX[WIDTH-1];
  assign sb          = signed_op & b_EX[WIDTH-1];
  assign mag_a       = cneg_w(a_EX, sa);
  assign mag_b       = cneg_w(b_EX, sb);

  assign busy        = (state_q != S_IDLE);
  assign stall_FETCH = busy & (start_EX | rd_req_EX | mt_we_EX);
  assign rd_data_EX  = sel_hi_EX ? hi_q : lo_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

  // One iteration: shift-add for multiply, trial subtract for restoring divide.
  always_comb begin
    x_s   = step_is_div ? {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} : acc_q[2*WIDTH:WIDTH];
    y_s   = step_is_div ? ~{2'b00, m_q} : {2'b00, m_q};
    sum_s = {1'b0, x_s} + y_s + {{(WIDTH+1){1'b0}}, step_is_div};
    rem_s = sum_s[WIDTH+1] ? x_s : sum_s[WIDTH:0];
    if (step_is_div) begin
      acc_d = {rem_s, acc_q[WIDTH-2:0], ~sum_s[WIDTH+1]};
    end else if (acc_q[0]) begin
      acc_d = {1'b0, sum_s[WIDTH:0], acc_q[WIDTH-1:1]};
    end else begin
      acc_d = {1'b0, acc_q[2*WIDTH:WIDTH], acc_q[WIDTH-1:1]};
    end
  end

  // Sign fixup of the finished magnitude result; divide-by-zero bypasses it.
  always_comb begin
    prod_s = cneg_2w(acc_q[2*WIDTH-1:0], neg_q);
    hi_fix = prod_s[2*WIDTH-1:WIDTH];
    lo_fix = prod_s[WIDTH-1:0];
    if (op_is_div) begin
      if (dvz_q) begin
        hi_fix = a_raw_q;
        lo_fix = '1;
      end else begin
        hi_fix = cneg_w(acc_q[2*WIDTH-1:WIDTH], rneg_q);
        lo_fix = cneg_w(acc_q[WIDTH-1:0], neg_q);
      end
    end
  end

  // Operand/accumulator datapath; meaningful only while a sequence is running.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= hilo_op_t'(op_EX);
      a_raw_q <= a_EX;
      m_q     <= mag_b;
      acc_q   <= {{(WIDTH+1){1'b0}}, mag_a};
      neg_q   <= sa ^ sb;
      rneg_q  <= sa;
      dvz_q   <= new_is_div && (b_EX == '0);
    end else if (state_q == S_MUL || state_q == S_DIV) begin
      acc_q   <= acc_d;
    end
  end

  // Control FSM plus architectural HI/LO and the divide-by-zero pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      dbz_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_EX) begin
            state_q <= new_is_div ? S_DIV : S_MUL;
            cnt_q   <= '0;
          end else if (mt_we_EX) begin
            if (sel_hi_EX) hi_q <= mt_data_EX;
            else           lo_q <= mt_data_EX;
          end
        end
        S_MUL, S_DIV: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          hi_q    <= hi_fix;
          lo_q    <= lo_fix;
          dbz_q   <= op_is_div & dvz_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_sequencer.sv
// Scoreboard bench for hilo_sequencer: expectations are queued at stimulus
// time and popped when the sequencer drops busy.
module tb_hilo_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_EX = 1'b0;
  logic [1:0]  op_EX = 2'd0;
  logic [31:0] a_EX = '0, b_EX = '0;
  logic        rd_req_EX = 1'b0, mt_we_EX = 1'b0, sel_hi_EX = 1'b0;
  logic [31:0] mt_data_EX = '0;
  logic [31:0] rd_data_EX, hi, lo;
  logic        stall_FETCH, busy, div_by_zero;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  hilo_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_EX(start_EX), .op_EX(op_EX), .a_EX(a_EX), .b_EX(b_EX),
    .rd_req_EX(rd_req_EX), .mt_we_EX(mt_we_EX), .sel_hi_EX(sel_hi_EX), .mt_data_EX(mt_data_EX),
    .rd_data_EX(rd_data_EX), .stall_FETCH(stall_FETCH), .busy(busy), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  // Reference behaviour built from native wide arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, q, r;
    logic [63:0] p;
    e.dbz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFFFFFF; e.dbz = 1'b1;
        end else if (op == 2'd2) begin
          q = sa / sb; r = sa % sb;
          e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Issue one op, then count busy cycles (bounded) until the result lands.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int ncyc, output logic dbz_seen);
    @(negedge clk);
    start_EX = 1'b1; op_EX = op; a_EX = a; b_EX = b;
    @(negedge clk);
    start_EX = 1'b0;
    ncyc = 0;
    while (busy && ncyc < 100) begin
      ncyc++;
      @(negedge clk);
    end
    dbz_seen = div_by_zero;
  endtask

  task automatic test_reset();
    #1;
    rd_req_EX = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (stall_FETCH !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_FETCH); end
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL reset_hilo got=%h/%h want=0/0", hi, lo); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    rd_req_EX = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mul();
    for (int i = 0; i < 6; i++) begin
      logic [1:0] op; logic [31:0] a, b; int n; logic d; exp_t e;
      if (i == 0) begin
        op = 2'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        sb_q.push_back('{hi: 32'hFFFFFFFE, lo: 32'h00000001, dbz: 1'b0});
      end else if (i == 1) begin
        op = 2'd0; a = 32'hFFFFFFFD; b = 32'd5;
        sb_q.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFF1, dbz: 1'b0});
      end else begin
        op = 2'($urandom_range(0, 1)); a = $urandom; b = $urandom;
        sb_q.push_back(model(op, a, b));
      end
      run_op(op, a, b, n, d);
      e = sb_q.pop_front();
      total++; if (n !== 33) begin bad++; $display("FAIL mul%0d_latency got=%0d want=33", i, n); end
      total++; if (hi !== e.hi) begin bad++; $display("FAIL mul%0d_hi got=%h want=%h", i, hi, e.hi); end
      total++; if (lo !== e.lo) begin bad++; $display("FAIL mul%0d_lo got=%h want=%h", i, lo, e.lo); end
      total++; if (d !== 1'b0) begin bad++; $display("FAIL mul%0d_dbz got=%b want=0", i, d); end
    end
  endtask

  task automatic test_div();
    for (int i = 0; i < 7; i++) begin
      logic [1:0] op; logic [31:0] a, b; int n; logic d; exp_t e;
      case (i)
        0: begin op = 2'd2; a = 32'h80000000; b = 32'hFFFFFFFF;
                 sb_q.push_back('{hi: 32'h0, lo: 32'h80000000, dbz: 1'b0}); end
        1: begin op = 2'd2; a = 32'hFFFFFFF9; b = 32'd2;
                 sb_q.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, dbz: 1'b0}); end
        2: begin op = 2'd3; a = 32'd7; b = 32'd2;
                 sb_q.push_back('{hi: 32'd1, lo: 32'd3, dbz: 1'b0}); end
        default: begin
          op = 2'($urandom_range(2, 3)); a = $urandom; b = $urandom >> $urandom_range(0, 28);
          if (b == 32'd0) b = 32'd3;
          sb_q.push_back(model(op, a, b));
        end
      endcase
      run_op(op, a, b, n, d);
      e = sb_q.pop_front();
      total++; if (n !== 33) begin bad++; $display("FAIL div%0d_latency got=%0d want=33", i, n); end
      total++; if (hi !== e.hi) begin bad++; $display("FAIL div%0d_hi got=%h want=%h", i, hi, e.hi); end
      total++; if (lo !== e.lo) begin bad++; $display("FAIL div%0d_lo got=%h want=%h", i, lo, e.lo); end
      total++; if (d !== 1'b0) begin bad++; $display("FAIL div%0d_dbz got=%b want=0", i, d); end
    end
  endtask

  task automatic test_div_zero();
    for (int i = 0; i < 2; i++) begin
      logic [1:0] op; logic [31:0] a; int n; logic d; exp_t e;
      if (i == 0) begin
        op = 2'd3; a = 32'd10;
        sb_q.push_back('{hi: 32'h0000000A, lo: 32'hFFFFFFFF, dbz: 1'b1});
      end else begin
        op = 2'd2; a = 32'hFFFFFFFB;
        sb_q.push_back(model(op, a, 32'd0));
      end
      run_op(op, a, 32'd0, n, d);
      e = sb_q.pop_front();
      total++; if (n !== 33) begin bad++; $display("FAIL dz%0d_latency got=%0d want=33", i, n); end
      total++; if (hi !== e.hi) begin bad++; $display("FAIL dz%0d_hi got=%h want=%h", i, hi, e.hi); end
      total++; if (lo !== e.lo) begin bad++; $display("FAIL dz%0d_lo got=%h want=%h", i, lo, e.lo); end
      total++; if (d !== e.dbz) begin bad++; $display("FAIL dz%0d_pulse got=%b want=%b", i, d, e.dbz); end
      @(negedge clk);
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dz%0d_pulse_end got=%b want=0", i, div_by_zero); end
    end
  endtask

  task automatic test_mt();
    logic [31:0] lo_before; int n; exp_t e;
    lo_before = lo;
    @(negedge clk);
    mt_we_EX = 1'b1; sel_hi_EX = 1'b1; mt_data_EX = 32'h00001234;
    #1;
    total++; if (stall_FETCH !== 1'b0) begin bad++; $display("FAIL mthi_stall got=%b want=0", stall_FETCH); end
    @(negedge clk);
    mt_we_EX = 1'b0;
    total++; if (hi !== 32'h00001234) begin bad++; $display("FAIL mthi_hi got=%h want=00001234", hi); end
    total++; if (lo !== lo_before) begin bad++; $display("FAIL mthi_lo got=%h want=%h", lo, lo_before); end
    mt_we_EX = 1'b1; sel_hi_EX = 1'b0; mt_data_EX = 32'hCAFE0001;
    @(negedge clk);
    mt_we_EX = 1'b0;
    total++; if (lo !== 32'hCAFE0001 || hi !== 32'h00001234) begin
      bad++; $display("FAIL mtlo got=%h/%h want=00001234/cafe0001", hi, lo); end
    // start and MT together: the MT write must be dropped
    sb_q.push_back(model(2'd1, 32'd2, 32'd3));
    start_EX = 1'b1; op_EX = 2'd1; a_EX = 32'd2; b_EX = 32'd3;
    mt_we_EX = 1'b1; sel_hi_EX = 1'b1; mt_data_EX = 32'h0000DEAD;
    @(negedge clk);
    start_EX = 1'b0; mt_we_EX = 1'b0;
    total++; if (hi !== 32'h00001234) begin bad++; $display("FAIL mt_dropped got=%h want=00001234", hi); end
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    e = sb_q.pop_front();
    total++; if (n !== 33 || lo !== e.lo || hi !== e.hi) begin
      bad++; $display("FAIL mt_then_mul got=%0d %h/%h want=33 %h/%h", n, hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_stall_read();
    int n; exp_t e;
    sb_q.push_back(model(2'd0, 32'hFFFFFFF9, 32'd6));
    @(negedge clk);
    start_EX = 1'b1; op_EX = 2'd0; a_EX = 32'hFFFFFFF9; b_EX = 32'd6;
    @(negedge clk);
    start_EX = 1'b0; rd_req_EX = 1'b1; sel_hi_EX = 1'b0;
    n = 0;
    while (stall_FETCH && n < 100) begin n++; @(negedge clk); end
    e = sb_q.pop_front();
    total++; if (n !== 33) begin bad++; $display("FAIL mflo_stall_cycles got=%0d want=33", n); end
    total++; if (rd_data_EX !== e.lo) begin bad++; $display("FAIL mflo_data got=%h want=%h", rd_data_EX, e.lo); end
    sel_hi_EX = 1'b1;
    #1;
    total++; if (rd_data_EX !== e.hi) begin bad++; $display("FAIL mfhi_data got=%h want=%h", rd_data_EX, e.hi); end
    rd_req_EX = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n, nstall; exp_t e;
    sb_q.push_back(model(2'd2, 32'hFFFFFFF9, 32'd2));
    sb_q.push_back(model(2'd1, 32'h00010000, 32'h00010000));
    @(negedge clk);
    start_EX = 1'b1; op_EX = 2'd2; a_EX = 32'hFFFFFFF9; b_EX = 32'd2;
    @(negedge clk);
    op_EX = 2'd1; a_EX = 32'h00010000; b_EX = 32'h00010000;
    n = 0; nstall = 0;
    while (busy && n < 100) begin
      n++;
      if (stall_FETCH) nstall++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    total++; if (n !== 33 || nstall !== 33) begin
      bad++; $display("FAIL b2b_first_busy got=%0d/%0d want=33/33", n, nstall); end
    total++; if (hi !== e.hi || lo !== e.lo) begin
      bad++; $display("FAIL b2b_first_result got=%h/%h want=%h/%h", hi, lo, e.hi, e.lo); end
    @(negedge clk);
    start_EX = 1'b0;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    e = sb_q.pop_front();
    total++; if (n !== 33) begin bad++; $display("FAIL b2b_second_busy got=%0d want=33", n); end
    total++; if (hi !== e.hi || lo !== e.lo) begin
      bad++; $display("FAIL b2b_second_result got=%h/%h want=%h/%h", hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_reset_abort();
    int n; logic d; exp_t e;
    @(negedge clk);
    start_EX = 1'b1; op_EX = 2'd1; a_EX = 32'hFFFFFFFF; b_EX = 32'hFFFFFFFF;
    @(negedge clk);
    start_EX = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL abort_hilo got=%h/%h want=0/0", hi, lo); end
    @(negedge clk);
    rst = 1'b1;
    sb_q.push_back('{hi: 32'd0, lo: 32'd6, dbz: 1'b0});
    run_op(2'd1, 32'd2, 32'd3, n, d);
    e = sb_q.pop_front();
    total++; if (n !== 33 || hi !== e.hi || lo !== e.lo) begin
      bad++; $display("FAIL abort_then_multu got=%0d %h/%h want=33 %h/%h", n, hi, lo, e.hi, e.lo); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_mt();
    test_stall_read();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_sequencer.md
# hilo_sequencer

Iterative multiply/divide controller that owns the HI/LO register pair for the two-stage MIPS core. It accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a 32-iteration shift-add or restoring-divide sequence. It serves MFHI/MFLO/MTHI/MTLO and stalls fetch while a result is pending. It replaces the single-cycle hi/lo path of the ALU.

## Interface

- Parameter `WIDTH`, default 32: operand width; iteration count equals `WIDTH`.
- Clock/reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start_EX`  in  1  mul/div instruction in execute.
- `op_EX`  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `a_EX`, `b_EX`  in  WIDTH  rs and rt operands.
- `rd_req_EX`  in  1  MFHI/MFLO in execute.
- `mt_we_EX`  in  1  MTHI/MTLO in execute.
- `sel_hi_EX`  in  1  1=HI, 0=LO, for read and write.
- `mt_data_EX`  in  WIDTH  MTHI/MTLO data.
- `rd_data_EX`  out  WIDTH  combinational `sel_hi_EX ? hi : lo`.
- `stall_FETCH`  out  1  hold fetch and the execute instruction.
- `busy`  out  1  state != IDLE.
- `div_by_zero`  out  1  one-cycle pulse when a DIV/DIVU with `b_EX`=0 completes.
- `hi`, `lo`  out  WIDTH  architectural HI/LO.

## Operation

- States:
  - IDLE -> MUL or DIV on `start_EX`: latch operand magnitudes (signed ops), result signs, and the op; clear counter.
  - MUL/DIV -> one iteration per cycle; leave for FIXUP after 32 iterations.
  - FIXUP -> apply signs, write HI/LO -> IDLE.
- MUL: 64-bit shift-add on magnitudes. Product is negated (64-bit two's complement) if the operand signs differ (signed op only). HI = product[63:32], LO = product[31:0].
- DIV: restoring division on magnitudes.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend. LO = quotient, HI = remainder.
  - 0x80000000 / -1: LO=0x80000000, HI=0.
  - Divisor 0: full latency still runs; LO=0xFFFFFFFF, HI=`a_EX` as supplied, sign fixup skipped, `div_by_zero` pulses in the FIXUP->IDLE cycle.
- MT write: in IDLE, the selected register takes `mt_data_EX` at the edge. The other register is unchanged.
- Priority in IDLE: `start_EX` > `mt_we_EX`. The two cannot legally coexist; if both are asserted, the MT write is dropped.
- `stall_FETCH` = `busy & (start_EX | rd_req_EX | mt_we_EX)`, combinational.
- While `busy`: a new `start_EX` is not accepted. The pipeline holds the instruction until IDLE.
- `rd_data_EX` is valid whenever `stall_FETCH`=0.

## Timing

- Reset values: state IDLE, counter 0, `hi`=`lo`=0, `busy`=0, `stall_FETCH`=0, `div_by_zero`=0.
- Reset during an operation aborts it immediately; HI/LO clear to 0.
- Start accepted at edge k. Iterations run on edges k+1..k+32. FIXUP writes HI/LO at edge k+33.
- `busy` is high for 33 cycles (after edge k through edge k+33).
- A dependent MFHI/MFLO presented the cycle after acceptance sees `stall_FETCH` high for 33 cycles. It reads the new value in the cycle after edge k+33.
- A back-to-back start arriving in the FIXUP cycle is stalled; it is accepted at the first edge where the state is IDLE.

## Structure

- Shared package `cpu_pkg` holds:
  - `hilo_op_t` (MULT, MULTU, DIV, DIVU);
  - `hilo_state_t` (IDLE, MUL, DIV, FIXUP);
  - `HILO_ITERS` = 32.
- One module, no sub-module. The iteration step is a single shared adder/subtractor on a 65-bit accumulator.
- The core instantiates it beside the ALU. `stall_FETCH` is ORed into the fetch stall.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 2 -> LO=3, HI=1.
- DIVU 10 / 0 -> LO=0xFFFFFFFF, HI=0x0000000A, `div_by_zero` high exactly one cycle at completion.
- MULT then MFLO on the next cycle -> `stall_FETCH` high 33 cycles, then `rd_data_EX`=LO. MTHI 0x1234 while IDLE -> `hi`=0x1234 next edge, no stall.
- `rst` low during iteration 10 -> `busy`=0, HI=LO=0 immediately. A following MULTU 2×3 completes normally (LO=6).
